arf124b256e1r1w0cbbehcaa4acw_wr_stage: RTL and testbench

Write-port staging block for the 124b x 256-entry 1R1W latch array. It sits directly upstream of the phase-B latch rows. It accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO. It then issues one write per cycle as registered data plus a registered one-hot row select, stable across the low clock phase in which the phase-B latches are transparent.

---
 rtl/arf124b256e1r1w0cbbehcaa4acw_wr_stage.sv | 171 +++++++++++++++++
 tb/tb_arf124b256e1r1w0cbbehcaa4acw_wr_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_wr_stage.sv
// Write-port staging for the 124b x 256-entry 1R1W latch array: 2-deep request FIFO feeding registered data/row-select.
// Optional power-up zero sweep of every row: define ARF124B256E1R1W0CBBEHCAA4ACW_WR_INIT_EN.
module arf124b256e1r1w0cbbehcaa4acw_wr_stage #(
   parameter int DWIDTH  = 124,
   parameter int ENTRIES = 256,
   parameter int AWIDTH  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [AWIDTH-1:0]  wr_adr,
   input  logic [DWIDTH-1:0]  wr_data,
   input  logic               wr_stall,
   output logic               wr_issue,
   output logic [ENTRIES-1:0] wr_row_sel,
   output logic [DWIDTH-1:0]  wr_data_q,
   output logic               wr_err_oor,
   output logic [1:0]         fifo_cnt,
   output logic               init_done
);

   localparam logic [AWIDTH:0]   ENTRIES_W = (AWIDTH+1)'(ENTRIES);
   localparam logic [AWIDTH-1:0] LAST_ROW  = AWIDTH'(ENTRIES - 1);

   logic [AWIDTH-1:0]  fifo_adr_q  [2];
   logic [DWIDTH-1:0]  fifo_data_q [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               issue_q, issue_d;
   logic               err_q, err_d;
   logic [ENTRIES-1:0] row_sel_q, row_sel_d;
   logic [DWIDTH-1:0]  dout_q, dout_d;

   logic               push_s, pop_s, head_oor_s;
   logic [AWIDTH-1:0]  head_adr_s;
   logic [DWIDTH-1:0]  head_data_s;
   logic               init_done_s, init_run_s;
   logic [AWIDTH-1:0]  init_row_s;

   function automatic logic [ENTRIES-1:0] onehot(input logic [AWIDTH-1:0] adr);
      logic [ENTRIES-1:0] v;
      v = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         v[i] = (adr == AWIDTH'(i));
      end
      return v;
   endfunction

`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_WR_INIT_EN
   localparam logic [1:0] INIT_IDLE = 2'd0;
   localparam logic [1:0] INIT_RUN  = 2'd1;
   localparam logic [1:0] INIT_DONE = 2'd2;

   logic [1:0]        init_st_q, init_st_d;
   logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;

   assign init_done_s = (init_st_q == INIT_DONE);
   assign init_run_s  = (init_st_q == INIT_RUN) & ~wr_stall;
   assign init_row_s  = init_cnt_q;

   // Init sweep sequencing: the row counter only advances on unstalled cycles.
   always_comb begin
      init_st_d  = init_st_q;
      init_cnt_d = init_cnt_q;
      case (init_st_q)
         INIT_IDLE: init_st_d = INIT_RUN;
         INIT_RUN: begin
            if (~wr_stall) begin
               if (init_cnt_q == LAST_ROW) begin
                  init_st_d = INIT_DONE;
               end else begin
                  init_cnt_d = init_cnt_q + AWIDTH'(1);
               end
            end else begin
               init_cnt_d = init_cnt_q;
            end
         end
         INIT_DONE: init_st_d = INIT_DONE;
         default:   init_st_d = INIT_IDLE;
      endcase
   end

   // Init state registers; reset restarts the sweep from row 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_st_q  <= INIT_IDLE;
         init_cnt_q <= '0;
      end else begin
         init_st_q  <= init_st_d;
         init_cnt_q <= init_cnt_d;
      end
   end
`else
   assign init_done_s = 1'b1;
   assign init_run_s  = 1'b0;
   assign init_row_s  = '0;
`endif

   assign head_adr_s  = fifo_adr_q[rd_ptr_q];
   assign head_data_s = fifo_data_q[rd_ptr_q];
   assign head_oor_s  = ({1'b0, head_adr_s} >= ENTRIES_W);
   assign pop_s       = (cnt_q != 2'd0) & ~wr_stall & ~rst;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign wr_ready    = ((cnt_q != 2'd2) | pop_s) & init_done_s & ~rst;
   assign push_s      = wr_valid & wr_ready;

   // FIFO bookkeeping and next-cycle issue registers.
   always_comb begin
      rd_ptr_d  = rd_ptr_q ^ pop_s;
      wr_ptr_d  = wr_ptr_q ^ push_s;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      issue_d   = 1'b0;
      err_d     = 1'b0;
      row_sel_d = '0;
      dout_d    = dout_q;
      if (pop_s) begin
         if (head_oor_s) begin
            err_d = 1'b1;
         end else begin
            issue_d   = 1'b1;
            row_sel_d = onehot(head_adr_s);
            dout_d    = head_data_s;
         end
      end else if (init_run_s) begin
         issue_d   = 1'b1;
         row_sel_d = onehot(init_row_s);
         dout_d    = '0;
      end else begin
         issue_d = 1'b0;
      end
   end

   // State registers; FIFO storage needs no reset since occupancy gates its use.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         issue_q   <= 1'b0;
         err_q     <= 1'b0;
         row_sel_q <= '0;
         dout_q    <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         issue_q   <= issue_d;
         err_q     <= err_d;
         row_sel_q <= row_sel_d;
         dout_q    <= dout_d;
         if (push_s) begin
            fifo_adr_q[wr_ptr_q]  <= wr_adr;
            fifo_data_q[wr_ptr_q] <= wr_data;
         end
      end
   end

   assign wr_issue   = issue_q;
   assign wr_row_sel = row_sel_q;
   assign wr_data_q  = dout_q;
   assign wr_err_oor = err_q;
   assign fifo_cnt   = cnt_q;
   assign init_done  = init_done_s;

endmodule

// File: tb/tb_arf124b256e1r1w0cbbehcaa4acw_wr_stage.sv
// Bench: two instances (256 and 200 rows) share stimulus; a queue model predicts every output.
module tb_arf124b256e1r1w0cbbehcaa4acw_wr_stage;
   localparam int DW = 124;
   localparam int EA = 256;
   localparam int EB = 200;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst, wr_valid, wr_stall;
   logic [AW-1:0] wr_adr;
   logic [DW-1:0] wr_data;

   logic wr_ready_a, wr_issue_a, wr_err_oor_a, init_done_a;
   logic [EA-1:0] wr_row_sel_a;
   logic [DW-1:0] wr_data_q_a;
   logic [1:0] fifo_cnt_a;
   logic wr_ready_b, wr_issue_b, wr_err_oor_b, init_done_b;
   logic [EB-1:0] wr_row_sel_b;
   logic [DW-1:0] wr_data_q_b;
   logic [1:0] fifo_cnt_b;

   arf124b256e1r1w0cbbehcaa4acw_wr_stage #(.DWIDTH(DW), .ENTRIES(EA), .AWIDTH(AW)) dut_a (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_adr(wr_adr),
      .wr_data(wr_data), .wr_stall(wr_stall), .wr_issue(wr_issue_a), .wr_row_sel(wr_row_sel_a),
      .wr_data_q(wr_data_q_a), .wr_err_oor(wr_err_oor_a), .fifo_cnt(fifo_cnt_a), .init_done(init_done_a));

   arf124b256e1r1w0cbbehcaa4acw_wr_stage #(.DWIDTH(DW), .ENTRIES(EB), .AWIDTH(AW)) dut_b (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_adr(wr_adr),
      .wr_data(wr_data), .wr_stall(wr_stall), .wr_issue(wr_issue_b), .wr_row_sel(wr_row_sel_b),
      .wr_data_q(wr_data_q_b), .wr_err_oor(wr_err_oor_b), .fifo_cnt(fifo_cnt_b), .init_done(init_done_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] q_adr[$];
   logic [DW-1:0] q_data[$];
   logic [255:0]  exp_sel_a, exp_sel_b;
   logic          exp_iss_a, exp_iss_b, exp_err_a, exp_err_b;
   logic [DW-1:0] exp_dat_a, exp_dat_b;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // One clock cycle: drive inputs, check handshake, clock, then check registered outputs.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic s, input logic r);
      logic exp_rdy, acc, pp, exp_init;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      wr_valid = v; wr_adr = a; wr_data = d; wr_stall = s; rst = r;
      #1;
      pp      = (q_adr.size() > 0) && !s && !r;
      exp_rdy = (q_adr.size() < 2 || pp) && !r;
      acc     = v && exp_rdy;
      chk("wr_ready_a", 256'(wr_ready_a), 256'(exp_rdy));
      chk("wr_ready_b", 256'(wr_ready_b), 256'(exp_rdy));
      @(posedge clk);
      #1;
      exp_iss_a = 1'b0; exp_iss_b = 1'b0; exp_err_a = 1'b0; exp_err_b = 1'b0;
      exp_sel_a = '0;   exp_sel_b = '0;
      if (r) begin
         q_adr.delete(); q_data.delete();
         exp_dat_a = '0; exp_dat_b = '0;
      end else begin
         if (pp) begin
            pa = q_adr.pop_front();
            pd = q_data.pop_front();
            exp_iss_a = 1'b1; exp_sel_a[pa] = 1'b1; exp_dat_a = pd;
            if (int'(pa) >= EB) exp_err_b = 1'b1;
            else begin exp_iss_b = 1'b1; exp_sel_b[pa] = 1'b1; exp_dat_b = pd; end
         end
         if (acc) begin q_adr.push_back(a); q_data.push_back(d); end
      end
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_WR_INIT_EN
      exp_init = !r;
`else
      exp_init = 1'b1;
`endif
      chk("issue_a",   256'(wr_issue_a),   256'(exp_iss_a));
      chk("row_sel_a", 256'(wr_row_sel_a), exp_sel_a);
      chk("data_a",    256'(wr_data_q_a),  256'(exp_dat_a));
      chk("err_a",     256'(wr_err_oor_a), 256'(exp_err_a));
      chk("issue_b",   256'(wr_issue_b),   256'(exp_iss_b));
      chk("row_sel_b", 256'(wr_row_sel_b), exp_sel_b);
      chk("data_b",    256'(wr_data_q_b),  256'(exp_dat_b));
      chk("err_b",     256'(wr_err_oor_b), 256'(exp_err_b));
      chk("fifo_cnt_a", 256'(fifo_cnt_a),  256'(q_adr.size()));
      chk("fifo_cnt_b", 256'(fifo_cnt_b),  256'(q_adr.size()));
      chk("init_done_a", 256'(init_done_a), 256'(exp_init));
      chk("init_done_b", 256'(init_done_b), 256'(exp_init));
   endtask

`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_WR_INIT_EN
   task automatic wait_init();
      int k;
      logic [255:0] oh;
      k = 0;
      wr_valid = 1'b0; wr_stall = 1'b0; rst = 1'b0;
      for (int g = 0; g < 1000 && !(init_done_a && init_done_b); g++) begin
         @(posedge clk);
         #1;
         if (!init_done_a) chk("init_ready", 256'(wr_ready_a), 256'(0));
         if (wr_issue_a) begin
            oh = '0;
            oh[k[7:0]] = 1'b1;
            chk("init_sel", 256'(wr_row_sel_a), oh);
            chk("init_data", 256'(wr_data_q_a), 256'(0));
            k++;
         end
      end
      chk("init_rows", 256'(k), 256'(EA));
      chk("init_timeout", 256'(init_done_a && init_done_b), 256'(1));
      exp_dat_a = '0; exp_dat_b = '0;
   endtask
`endif

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_WR_INIT_EN
      wait_init();
`endif
   endtask

   initial begin
      logic [DW-1:0] a5;
      a5 = {{15{8'hA5}}, 4'hA};
      wr_valid = 1'b0; wr_stall = 1'b0; rst = 1'b1; wr_adr = '0; wr_data = '0;
      exp_dat_a = '0; exp_dat_b = '0;

      do_reset(2);

      // Single write, then an idle cycle that must hold the data.
      step(1'b1, 8'h05, a5, 1'b0, 1'b0);
      step(1'b0, 8'h00, '0, 1'b0, 1'b0);
      step(1'b0, 8'h00, '0, 1'b0, 1'b0);

      // Backpressure under stall, then in-order drain.
      step(1'b1, 8'd10, rnd(), 1'b1, 1'b0);
      step(1'b1, 8'd11, rnd(), 1'b1, 1'b0);
      step(1'b1, 8'd12, rnd(), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0, 1'b0, 1'b0);

      // Full FIFO with simultaneous push and pop: 10 requests streamed.
      step(1'b1, 8'd20, rnd(), 1'b1, 1'b0);
      step(1'b1, 8'd21, rnd(), 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(30 + i), rnd(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0, 1'b0, 1'b0);

      // Same row back-to-back; out-of-range for the 200-row instance, then row 0.
      step(1'b1, 8'd7, rnd(), 1'b0, 1'b0);
      step(1'b1, 8'd7, rnd(), 1'b0, 1'b0);
      step(1'b1, 8'd210, rnd(), 1'b0, 1'b0);
      step(1'b1, 8'd0, rnd(), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b0, 8'd0, '0, 1'b0, 1'b0);

      // Reset with two requests pending: nothing may issue afterwards.
      step(1'b1, 8'd40, rnd(), 1'b1, 1'b0);
      step(1'b1, 8'd41, rnd(), 1'b1, 1'b0);
      do_reset(1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0, 1'b0, 1'b0);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset(1);
         else step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), rnd(),
                   $urandom_range(0, 3) == 0, 1'b0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, '0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
